// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single regfile write port (we3/a3/wd3) between the pipeline
//   WB stage (P, cannot be back-pressured) and a multi-cycle unit (M, valid/ready).
//   P has priority. If M is starved for STARVE_MAX cycles, a one-cycle pipeline
//   stall is forced and M takes the port. A 32-entry pending-write scoreboard
//   lets decode stall on RAW hazards against in-flight M operations.
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   p_we, p_rd, p_wd           WB stage write request
//   m_valid, m_rd, m_wd        M result; m_ready acknowledges it
//   iss_valid, iss_rd          decode issuing an M op; iss_ready = rd not pending
//   q_rs1, q_rs2               decode source queries; rs1_busy/rs2_busy results
//   pipe_stall                 freeze IF..WB for this cycle
//   we3, a3, wd3               regfile write port (combinational)
//
// Build option
//   WB_ARB_EARLY_CLEAR_EN      busy drops in the same cycle the M result commits
//
// FSM states
//   state   | meaning
//   S_IDLE  | M not waiting (or granted this cycle)
//   S_WAIT  | M valid but not granted; r_cnt counts cycles waited
//   S_FORCE | one-cycle stall, P masked, M owns the port

module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_we,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_wd,
  input  logic            m_valid,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_wd,
  output logic            m_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            pipe_stall,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  localparam logic [STARVE_W:0] LP_MAX = STARVE_MAX[STARVE_W:0];
  localparam logic [STARVE_W:0] LP_ONE = {{STARVE_W{1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic [STARVE_W-1:0] r_cnt, w_cnt_nxt;
  logic [STARVE_W:0]   w_cnt_inc;
  logic [31:0]         r_sb, w_sb_nxt;
  logic                w_p_req;
  logic                w_m_fire;
  logic                w_iss_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Extra bit so the compare against STARVE_MAX cannot wrap
  assign w_cnt_inc = {1'b0, r_cnt} + LP_ONE;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (m_valid && !m_ready) begin
          w_cnt_nxt   = LP_ONE[STARVE_W-1:0];
          w_state_nxt = (LP_ONE == LP_MAX) ? S_FORCE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc[STARVE_W-1:0];
          if (w_cnt_inc == LP_MAX) w_state_nxt = S_FORCE;
        end
      end
      S_FORCE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: everything is gated by reset_n so outputs are quiet while reset is held
  always_comb begin
    pipe_stall = reset_n && (r_state == S_FORCE);
    w_p_req    = reset_n && p_we && (p_rd != 5'd0) && !pipe_stall;
    // An x0 result never needs the port, so it is taken even when P writes
    m_ready    = reset_n && m_valid && (!w_p_req || (m_rd == 5'd0));
    we3        = 1'b0;
    a3         = '0;
    wd3        = '0;
    if (w_p_req) begin
      we3 = 1'b1;
      a3  = p_rd;
      wd3 = p_wd;
    end else if (m_ready && (m_rd != 5'd0)) begin
      we3 = 1'b1;
      a3  = m_rd;
      wd3 = m_wd;
    end
  end

  // Pending-write scoreboard
  assign iss_ready  = reset_n && !r_sb[iss_rd];
  assign w_m_fire   = m_valid && m_ready;
  assign w_iss_fire = iss_valid && iss_ready && (iss_rd != 5'd0);

  always_comb begin
    w_sb_nxt = r_sb;
    if (w_m_fire)   w_sb_nxt[m_rd]   = 1'b0;
    if (w_iss_fire) w_sb_nxt[iss_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_sb <= '0;
    else          r_sb <= w_sb_nxt;
  end

`ifdef WB_ARB_EARLY_CLEAR_EN
  assign rs1_busy = reset_n && r_sb[q_rs1] && !(w_m_fire && (m_rd == q_rs1));
  assign rs2_busy = reset_n && r_sb[q_rs2] && !(w_m_fire && (m_rd == q_rs2));
`else
  assign rs1_busy = reset_n && r_sb[q_rs1];
  assign rs2_busy = reset_n && r_sb[q_rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default parameters, STARVE_MAX=4).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_we;
  logic [4:0]  p_rd;
  logic [31:0] p_wd;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        pipe_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .m_valid(m_valid), .m_rd(m_rd), .m_wd(m_wd), .m_ready(m_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pipe_stall(pipe_stall), .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic idle();
    p_we = 1'b0; p_rd = '0; p_wd = '0;
    m_valid = 1'b0; m_rd = '0; m_wd = '0;
    iss_valid = 1'b0; iss_rd = '0;
    q_rs1 = '0; q_rs2 = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p_we = 1'b1; p_rd = 5'd5; p_wd = 32'h1234_5678;
    m_valid = 1'b1; m_rd = 5'd7; m_wd = 32'h8765_4321;
    iss_valid = 1'b1; iss_rd = 5'd3; q_rs1 = 5'd3; q_rs2 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({m_ready, we3, pipe_stall, rs1_busy, rs2_busy, iss_ready} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl cyc%0d: got {m_ready,we3,stall,busy1,busy2,iss_ready}=%b expected 000000",
                 i, {m_ready, we3, pipe_stall, rs1_busy, rs2_busy, iss_ready});
      end
      checks++;
      if ({a3, wd3} !== 37'h0) begin
        errors++;
        $display("FAIL reset_port cyc%0d: got a3=%0d wd3=%h expected 0 0", i, a3, wd3);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    q_rs1 = 5'd3; iss_rd = 5'd3;
    #1;
    checks++;
    if ({rs1_busy, iss_ready, pipe_stall, we3} !== 4'b0100) begin
      errors++;
      $display("FAIL after_reset: got {busy1,iss_ready,stall,we3}=%b expected 0100",
               {rs1_busy, iss_ready, pipe_stall, we3});
    end
  endtask

  task automatic test_p_only();
    @(negedge clk);
    idle();
    p_we = 1'b1; p_rd = 5'd5; p_wd = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({we3, a3, wd3, m_ready, pipe_stall} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL p_only: got we3=%b a3=%0d wd3=%h m_ready=%b expected 1 5 deadbeef 0",
               we3, a3, wd3, m_ready);
    end
    @(negedge clk);
    p_rd = 5'd0;
    #1;
    checks++;
    if (we3 !== 1'b0) begin
      errors++;
      $display("FAIL p_x0: got we3=%b expected 0", we3);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      p_we = 1'b1; p_rd = 5'd3; p_wd = 32'h0000_1111;
      m_valid = 1'b1; m_rd = 5'd7; m_wd = 32'h0000_7777;
      #1;
      checks++;
      if ({we3, a3, wd3, m_ready, pipe_stall} !== {1'b1, 5'd3, 32'h1111, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL conflict_p cyc%0d: got we3=%b a3=%0d wd3=%h m_ready=%b stall=%b expected 1 3 1111 0 0",
                 i, we3, a3, wd3, m_ready, pipe_stall);
      end
    end
    @(negedge clk);
    p_we = 1'b0;
    #1;
    checks++;
    if ({we3, a3, wd3, m_ready, pipe_stall} !== {1'b1, 5'd7, 32'h7777, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL conflict_m: got we3=%b a3=%0d wd3=%h m_ready=%b stall=%b expected 1 7 7777 1 0",
               we3, a3, wd3, m_ready, pipe_stall);
    end
    @(negedge clk);
    idle();
  endtask

  // P busy every cycle, M valid from t0; forced slot at t4. With keep_m=0 M drops at t4.
  task automatic starve_prefix();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      p_we = 1'b1; p_rd = 5'(t + 1); p_wd = 32'hA0 + 32'(t);
      m_valid = 1'b1; m_rd = 5'd12; m_wd = 32'h0000_C0C0;
      #1;
      checks++;
      if ({pipe_stall, m_ready, we3, a3} !== {1'b0, 1'b0, 1'b1, 5'(t + 1)}) begin
        errors++;
        $display("FAIL starve_t%0d: got stall=%b m_ready=%b we3=%b a3=%0d expected 0 0 1 %0d",
                 t, pipe_stall, m_ready, we3, a3, t + 1);
      end
    end
  endtask

  task automatic test_starvation();
    starve_prefix();
    @(negedge clk);
    p_rd = 5'd20;
    #1;
    checks++;
    if ({pipe_stall, m_ready, we3, a3, wd3} !== {1'b1, 1'b1, 1'b1, 5'd12, 32'hC0C0}) begin
      errors++;
      $display("FAIL starve_force: got stall=%b m_ready=%b we3=%b a3=%0d wd3=%h expected 1 1 1 12 c0c0",
               pipe_stall, m_ready, we3, a3, wd3);
    end
    @(negedge clk);
    m_valid = 1'b0; p_rd = 5'd21;
    #1;
    checks++;
    if ({pipe_stall, we3, a3} !== {1'b0, 1'b1, 5'd21}) begin
      errors++;
      $display("FAIL starve_t5: got stall=%b we3=%b a3=%0d expected 0 1 21", pipe_stall, we3, a3);
    end
    // Second round: M drops valid exactly in the forced cycle
    starve_prefix();
    @(negedge clk);
    m_valid = 1'b0; p_rd = 5'd22;
    #1;
    checks++;
    if ({pipe_stall, m_ready, we3} !== 3'b100) begin
      errors++;
      $display("FAIL force_empty: got stall=%b m_ready=%b we3=%b expected 1 0 0", pipe_stall, m_ready, we3);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({pipe_stall, we3, a3} !== {1'b0, 1'b1, 5'd22}) begin
      errors++;
      $display("FAIL force_empty_next: got stall=%b we3=%b a3=%0d expected 0 1 22", pipe_stall, we3, a3);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9; q_rs1 = 5'd9;
    #1;
    checks++;
    if ({iss_ready, rs1_busy} !== 2'b10) begin
      errors++;
      $display("FAIL sb_issue: got iss_ready=%b busy1=%b expected 1 0", iss_ready, rs1_busy);
    end
    @(negedge clk);
    q_rs2 = 5'd8;
    #1;
    checks++;
    if ({iss_ready, rs1_busy, rs2_busy} !== 3'b010) begin
      errors++;
      $display("FAIL sb_pending: got iss_ready=%b busy1=%b busy2=%b expected 0 1 0", iss_ready, rs1_busy, rs2_busy);
    end
    @(negedge clk);
    iss_valid = 1'b0;
    m_valid = 1'b1; m_rd = 5'd9; m_wd = 32'h0000_0099;
    #1;
    checks++;
    if ({m_ready, we3, a3} !== {1'b1, 1'b1, 5'd9}) begin
      errors++;
      $display("FAIL sb_commit: got m_ready=%b we3=%b a3=%0d expected 1 1 9", m_ready, we3, a3);
    end
`ifdef WB_ARB_EARLY_CLEAR_EN
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_commit_busy: got %b expected 0", rs1_busy);
    end
`else
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_commit_busy: got %b expected 1", rs1_busy);
    end
`endif
    @(negedge clk);
    idle();
    q_rs1 = 5'd9; iss_rd = 5'd9;
    #1;
    checks++;
    if ({rs1_busy, iss_ready} !== 2'b01) begin
      errors++;
      $display("FAIL sb_cleared: got busy1=%b iss_ready=%b expected 0 1", rs1_busy, iss_ready);
    end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd2;
    @(negedge clk);
    iss_rd = 5'd4;
    m_valid = 1'b1; m_rd = 5'd2; m_wd = 32'h0000_0222;
    #1;
    checks++;
    if ({iss_ready, m_ready, we3, a3} !== {1'b1, 1'b1, 1'b1, 5'd2}) begin
      errors++;
      $display("FAIL conc_cycle: got iss_ready=%b m_ready=%b we3=%b a3=%0d expected 1 1 1 2",
               iss_ready, m_ready, we3, a3);
    end
    @(negedge clk);
    idle();
    q_rs1 = 5'd4; q_rs2 = 5'd2;
    #1;
    checks++;
    if ({rs1_busy, rs2_busy} !== 2'b10) begin
      errors++;
      $display("FAIL conc_after: got busy1(r4)=%b busy2(r2)=%b expected 1 0", rs1_busy, rs2_busy);
    end
    @(negedge clk);
    m_valid = 1'b1; m_rd = 5'd4;
    @(negedge clk);
    idle();
    q_rs1 = 5'd4;
    #1;
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL conc_cleanup: got busy1(r4)=%b expected 0", rs1_busy);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    m_valid = 1'b1; m_rd = 5'd0; m_wd = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++;
    if ({m_ready, we3, iss_ready} !== 3'b101) begin
      errors++;
      $display("FAIL x0_m: got m_ready=%b we3=%b iss_ready=%b expected 1 0 1", m_ready, we3, iss_ready);
    end
    @(negedge clk);
    idle();
    q_rs1 = 5'd0;
    p_we = 1'b1; p_rd = 5'd0; p_wd = 32'h5555_5555;
    m_valid = 1'b1; m_rd = 5'd7; m_wd = 32'h0000_0777;
    #1;
    checks++;
    if ({rs1_busy, m_ready, we3, a3, wd3} !== {1'b0, 1'b1, 1'b1, 5'd7, 32'h777}) begin
      errors++;
      $display("FAIL x0_p_void: got busy1=%b m_ready=%b we3=%b a3=%0d wd3=%h expected 0 1 1 7 777",
               rs1_busy, m_ready, we3, a3, wd3);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_force();
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd15;
    @(negedge clk);
    idle();
    q_rs1 = 5'd15;
    #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got busy1=%b expected 1", rs1_busy);
    end
    starve_prefix();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pipe_stall, m_ready, we3} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_force: got stall=%b m_ready=%b we3=%b expected 0 0 0", pipe_stall, m_ready, we3);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    q_rs1 = 5'd15;
    #1;
    checks++;
    if ({pipe_stall, rs1_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_after: got stall=%b busy1(r15)=%b expected 0 0", pipe_stall, rs1_busy);
    end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_p_only();
    test_conflict();
    test_starvation();
    test_scoreboard();
    test_concurrent();
    test_x0();
    test_reset_mid_force();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
